// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module : pc_seq_pkg
// Brief  : Shared source encoding and constants for the pc_seq program counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ   = 3'd0,
    SRC_BR    = 3'd1,
    SRC_JR    = 3'd2,
    SRC_J     = 3'd3,
    SRC_PEND  = 3'd4,
    SRC_REDIR = 3'd5
  } pc_src_t;

  localparam int unsigned PC_INC = 4;

endpackage

`default_nettype wire

// File: rtl/pc_target_sel.sv
// ============================================================================
// Module : pc_target_sel
// Brief  : Fixed-priority next-pc mux: redirect > pending > branch > jr > j > seq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_target_sel
  import pc_seq_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic            beq,
  input  logic            bne,
  input  logic            zero,
  input  logic [PC_W-1:0] brval,
  input  logic            jr_sig,
  input  logic [PC_W-1:0] jr_val,
  input  logic            j_sig,
  input  logic [PC_W-1:0] j_val,
  input  logic            redir_valid,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            pend_valid,
  input  logic [PC_W-1:0] pend_pc,
  output logic [PC_W-1:0] tgt,
  output pc_src_t         src
);

  logic            w_br_take;
  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_br_tgt;

  always_comb begin
    // beq takes precedence when the decoder asserts both branch types
    w_br_take = beq ? zero : (bne & ~zero);
    w_seq     = pc + PC_W'(PC_INC);
    w_br_tgt  = w_seq + (brval << 2);
    tgt       = w_seq;
    src       = SRC_SEQ;
    if (redir_valid) begin
      tgt = redir_pc;
      src = SRC_REDIR;
    end else if (pend_valid) begin
      tgt = pend_pc;
      src = SRC_PEND;
    end else if (w_br_take) begin
      tgt = w_br_tgt;
      src = SRC_BR;
    end else if (jr_sig) begin
      tgt = jr_val;
      src = SRC_JR;
    end else if (j_sig) begin
      tgt = j_val;
      src = SRC_J;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_seq.sv
// ============================================================================
// Module : pc_seq
// Brief  : Program counter with stall-time transfer buffering and fetch counter.
//          Define PC_ALIGN_CHK_EN to force word alignment and flag misalignment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pc_en,
  input  logic             beq,
  input  logic             bne,
  input  logic             zero,
  input  logic [PC_W-1:0]  brval,
  input  logic             jr_sig,
  input  logic [PC_W-1:0]  jr_val,
  input  logic             j_sig,
  input  logic [PC_W-1:0]  j_val,
  input  logic             redir_valid,
  input  logic [PC_W-1:0]  redir_pc,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  npc,
  output logic             pend_valid,
  output logic             taken,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign
);

  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_pend_pc;
  logic             r_pend_valid;
  logic             r_taken;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic [PC_W-1:0]  w_tgt;
  logic [PC_W-1:0]  w_tgt_ld;
  pc_src_t          w_src;
  logic             w_pend_ld;

  pc_target_sel #(
    .PC_W (PC_W)
  ) u_sel (
    .pc          (r_pc),
    .beq         (beq),
    .bne         (bne),
    .zero        (zero),
    .brval       (brval),
    .jr_sig      (jr_sig),
    .jr_val      (jr_val),
    .j_sig       (j_sig),
    .j_val       (j_val),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .pend_valid  (r_pend_valid),
    .pend_pc     (r_pend_pc),
    .tgt         (w_tgt),
    .src         (w_src)
  );

  // A redirect always replaces the buffer; other transfers only fill an empty one
  assign w_pend_ld = ~pc_en &
                     ((w_src == SRC_REDIR) |
                      (~r_pend_valid & (w_src inside {SRC_BR, SRC_JR, SRC_J})));

`ifdef PC_ALIGN_CHK_EN
  logic r_misalign;

  assign w_tgt_ld = {w_tgt[PC_W-1:2], 2'b00};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_misalign <= 1'b0;
    end else if ((pc_en | w_pend_ld) && (w_tgt[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign = r_misalign;
`else
  assign w_tgt_ld = w_tgt;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc         <= RESET_PC;
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
      r_taken      <= 1'b0;
      r_fetch_cnt  <= '0;
    end else if (pc_en) begin
      r_pc         <= w_tgt_ld;
      r_pend_valid <= 1'b0;
      r_taken      <= (w_src != SRC_SEQ);
      if (r_fetch_cnt != {CNT_W{1'b1}}) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
    end else begin
      r_taken <= 1'b0;
      if (w_pend_ld) begin
        r_pend_pc    <= w_tgt_ld;
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign pc         = r_pc;
  assign npc        = r_pc + PC_W'(PC_INC);
  assign pend_valid = r_pend_valid;
  assign taken      = r_taken;
  assign fetch_cnt  = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_seq.sv
// ============================================================================
// Module : tb_pc_seq
// Brief  : Scoreboard bench for pc_seq: directed program-flow cases plus random.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_seq;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        pc_en, beq, bne, zero, jr_sig, j_sig, redir_valid;
  logic [31:0] brval, jr_val, j_val, redir_pc;
  logic [31:0] pc, npc;
  logic        pend_valid, taken, misalign;
  logic [15:0] fetch_cnt;
  logic [31:0] pc4, npc4;
  logic        pend_valid4, taken4, misalign4;
  logic [3:0]  fetch_cnt4;

  always #5 CLK = ~CLK;

  pc_seq u_dut (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .beq(beq), .bne(bne), .zero(zero),
    .brval(brval), .jr_sig(jr_sig), .jr_val(jr_val), .j_sig(j_sig), .j_val(j_val),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .pc(pc), .npc(npc),
    .pend_valid(pend_valid), .taken(taken), .fetch_cnt(fetch_cnt), .misalign(misalign)
  );

  pc_seq #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .beq(beq), .bne(bne), .zero(zero),
    .brval(brval), .jr_sig(jr_sig), .jr_val(jr_val), .j_sig(j_sig), .j_val(j_val),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .pc(pc4), .npc(npc4),
    .pend_valid(pend_valid4), .taken(taken4), .fetch_cnt(fetch_cnt4), .misalign(misalign4)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        pv;
    logic        taken;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        mis;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference state: architectural view of the sequencer
  logic [31:0] m_pc, m_pp;
  logic        m_pv, m_taken, m_mis;
  int          m_adv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("pc",         pc,                 mon_e.pc);
      check("npc",        npc,                mon_e.pc + 32'd4);
      check("pend_valid", {31'd0, pend_valid}, {31'd0, mon_e.pv});
      check("taken",      {31'd0, taken},      {31'd0, mon_e.taken});
      check("fetch_cnt",  {16'd0, fetch_cnt},  {16'd0, mon_e.cnt});
      check("fetch_cnt4", {28'd0, fetch_cnt4}, {28'd0, mon_e.cnt4});
      check("misalign",   {31'd0, misalign},   {31'd0, mon_e.mis});
    end
  end

  task automatic align(input logic [31:0] t, output logic [31:0] r);
    r = t;
`ifdef PC_ALIGN_CHK_EN
    if (t[1:0] != 2'b00) m_mis = 1'b1;
    r = {t[31:2], 2'b00};
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pp = 32'h0; m_pv = 1'b0; m_taken = 1'b0; m_mis = 1'b0; m_adv = 0;
  endtask

  // kind: 0 sequential, 1 branch/jr/j, 2 pending, 3 redirect
  task automatic model_step();
    logic [31:0] t, r;
    int k;
    exp_t e;
    if (redir_valid)                          begin t = redir_pc; k = 3; end
    else if (m_pv)                            begin t = m_pp; k = 2; end
    else if (beq ? zero : (bne && !zero))     begin t = m_pc + brval * 32'd4 + 32'd4; k = 1; end
    else if (jr_sig)                          begin t = jr_val; k = 1; end
    else if (j_sig)                           begin t = j_val; k = 1; end
    else                                      begin t = m_pc + 32'd4; k = 0; end
    if (pc_en) begin
      align(t, r);
      m_pc = r; m_pv = 1'b0; m_taken = (k != 0); m_adv++;
    end else begin
      m_taken = 1'b0;
      if (k == 3 || k == 1) begin
        align(t, r);
        m_pp = r; m_pv = 1'b1;
      end
    end
    e.pc = m_pc; e.pv = m_pv; e.taken = m_taken; e.mis = m_mis;
    e.cnt  = (m_adv > 65535) ? 16'hFFFF : 16'(m_adv);
    e.cnt4 = (m_adv > 15) ? 4'hF : 4'(m_adv);
    q.push_back(e);
  endtask

  task automatic clr(input logic en);
    pc_en = en; beq = 0; bne = 0; zero = 0; jr_sig = 0; j_sig = 0; redir_valid = 0;
    brval = 0; jr_val = 0; j_val = 0; redir_pc = 0;
  endtask

  task automatic tick();
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    model_reset();
    #1;
    check("rst_pc",   pc,                  32'h0);
    check("rst_pv",   {31'd0, pend_valid}, 32'h0);
    check("rst_tk",   {31'd0, taken},      32'h0);
    check("rst_cnt",  {16'd0, fetch_cnt},  32'h0);
    check("rst_mis",  {31'd0, misalign},   32'h0);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    clr(1'b0);
    model_reset();
    @(negedge CLK);
    do_reset();

    // sequential advance
    repeat (3) begin clr(1'b1); tick(); end

    // reach 0x100, branch back by one word, then untaken bne
    clr(1'b1); j_sig = 1; j_val = 32'h100; tick();
    clr(1'b1); beq = 1; zero = 1; brval = 32'hFFFF_FFFE; tick();
    clr(1'b1); bne = 1; zero = 1; brval = 32'h0000_0010; tick();

    // jump buffered across stall
    clr(1'b0); j_sig = 1; j_val = 32'h400; tick();
    repeat (2) begin clr(1'b0); tick(); end
    clr(1'b1); tick();

    // stalled: branch may not displace pend, redirect does
    clr(1'b0); j_sig = 1; j_val = 32'h400; tick();
    clr(1'b0); jr_sig = 1; jr_val = 32'h900; tick();
    clr(1'b0); redir_valid = 1; redir_pc = 32'h8000_0180; tick();
    clr(1'b0); tick();
    clr(1'b1); tick();

    // jr beats j; redirect beats pend on release
    clr(1'b1); jr_sig = 1; jr_val = 32'h2000; j_sig = 1; j_val = 32'h3000; tick();
    clr(1'b0); j_sig = 1; j_val = 32'h500; tick();
    clr(1'b1); redir_valid = 1; redir_pc = 32'h600; tick();

    // wrap-around
    clr(1'b1); j_sig = 1; j_val = 32'hFFFF_FFFC; tick();
    clr(1'b1); tick();

    // reset mid-stall drops the buffered transfer
    clr(1'b0); j_sig = 1; j_val = 32'h700; tick();
    clr(1'b0); do_reset();
    clr(1'b1); tick();

    // unaligned jump-register target
    clr(1'b1); jr_sig = 1; jr_val = 32'h203; tick();
    repeat (3) begin clr(1'b1); tick(); end

    for (int i = 0; i < 400; i++) begin
      clr($urandom_range(0, 9) < 7);
      beq = ($urandom_range(0, 5) == 0);
      bne = ($urandom_range(0, 5) == 0);
      zero = $urandom_range(0, 1);
      brval = 32'($urandom_range(0, 127)) - 32'd64;
      jr_sig = ($urandom_range(0, 6) == 0);
      jr_val = $urandom & 32'hFFFF_FFFC;
      j_sig = ($urandom_range(0, 6) == 0);
      j_val = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      redir_valid = ($urandom_range(0, 9) == 0);
      redir_pc = $urandom & 32'hFFFF_FFFC;
      tick();
    end

    clr(1'b0);
    for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge CLK);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised next-generation program counter for the single-cycle/pipelined datapath.
- Selects the next fetch address from sequential, branch (beq/bne), jump-register, jump and external redirect sources, with fixed priority.
- Buffers a control transfer that arrives while fetch is stalled, so it is not lost.
- Provides a saturating fetch counter and an optional alignment check. Sits between the control unit/hazard unit and the instruction memory address port.

Parameters:
- PC_W, 32, width of all addresses and offsets.
- RESET_PC, 32'h0000_0000, pc value loaded on reset.
- CNT_W, 16, width of the fetch counter.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- pc_en  in  1  advance enable; 0 = stall (pc holds).
- beq  in  1  branch-if-equal instruction in decode.
- bne  in  1  branch-if-not-equal instruction in decode.
- zero  in  1  ALU zero flag.
- brval  in  PC_W  sign-extended word offset.
- jr_sig  in  1  jump-register.
- jr_val  in  PC_W  jump-register target.
- j_sig  in  1  jump.
- j_val  in  PC_W  jump target.
- redir_valid  in  1  external flush/redirect (exception, mispredict).
- redir_pc  in  PC_W  redirect target.
- pc  out  PC_W  current fetch address (registered).
- npc  out  PC_W  pc+4, combinational.
- pend_valid  out  1  a buffered transfer is waiting (registered).
- taken  out  1  pc loaded a non-sequential target this edge (registered pulse).
- fetch_cnt  out  CNT_W  count of pc advances (registered).
- misalign  out  1  alignment error flag (registered).

Behaviour:
- Reset (async, nRST=0):
  - pc=RESET_PC.
  - pend_valid=0, pend_pc=0.
  - taken=0, fetch_cnt=0, misalign=0.
- Arithmetic:
  - All arithmetic is modulo 2^PC_W, so wrap-around is silent.
  - br_tgt = pc + (brval<<2) + 4.
  - br_take = (beq & zero) | (bne & ~zero). If beq and bne are both 1, beq is evaluated.
- Source priority, highest first: redir_valid, pend_valid, br_take, jr_sig, j_sig, sequential (npc).
- pc_en=1:
  - pc <= selected target. Latency is one edge.
  - pend_valid <= 0.
  - taken <= 1 if the source is not sequential, else 0.
  - fetch_cnt <= fetch_cnt+1, saturating at all-ones.
- pc_en=0:
  - pc holds, taken <= 0, fetch_cnt holds.
  - If any non-sequential source other than pend is active, pend_pc <= that target per priority and pend_valid <= 1.
  - A redirect while stalled overwrites an existing pend_pc.
  - A branch, jr or j overwrites only when pend_valid=0.
  - If no source is active, pend holds.
- Simultaneous redir_valid, pend_valid and pc_en=1: redirect wins and the pend entry is discarded.
- A pending entry survives any number of stall cycles.
- Reset mid-stall clears pend; the buffered transfer is dropped.
- npc is always pc+4, independent of pc_en.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - Any target loaded into pc or pend_pc with bits[1:0]!=0 has bits[1:0] forced to 00.
  - misalign <= 1 on that edge. misalign is sticky until reset.
- Undefined:
  - Targets are loaded unmodified.
  - misalign is tied 0 and no check logic is built.

Decomposition:
- Package pc_seq_pkg:
  - enum pc_src_t {SRC_SEQ, SRC_BR, SRC_JR, SRC_J, SRC_PEND, SRC_REDIR}.
  - Constant PC_INC=4.
- One sub-module, pc_target_sel:
  - Combinational priority mux.
  - Outputs the target value and pc_src_t from the source inputs, pend state and pc.
- The top level holds the pc, pend, counter and flag registers.

Test Plan:
- Reset then pc_en=1 for 3 cycles, no sources -> pc 0, 4, 8, 12; fetch_cnt=3; taken=0.
- At pc=0x100: beq=1, zero=1, brval=0xFFFF_FFFE, pc_en=1 -> pc=0xFC, taken=1. Then bne=1, zero=1 -> pc=0x100.
- pc_en=0, j_sig=1, j_val=0x400 for 1 cycle, then 2 idle stall cycles -> pend_valid=1 and pc held. Then pc_en=1 -> pc=0x400 and pend_valid=0.
- While stalled: pend holds 0x400, then redir_valid=1, redir_pc=0x8000_0180 -> pend overwritten. On release pc=0x8000_0180. Also jr_sig and j_sig together -> jr_val wins.
- pc=0xFFFF_FFFC, pc_en=1 -> pc=0x0000_0000. Separately, CNT_W=4 with 20 advances -> fetch_cnt=0xF.
- PC_ALIGN_CHK_EN defined, jr_val=0x203 -> pc=0x200, misalign=1 and stays 1. Undefined build -> pc=0x203, misalign=0.
